fifo_umbrales: RTL and testbench

Synchronous FIFO with programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flag. It is the data-path counterpart of the flow-control state machine. It consumes the threshold values that machine latches during its INIT state. It reports the `empty` and `error` status bits that the machine gathers into its 5-bit FIFO status vectors, one instance per bit.

---
 rtl/fifo_umbrales_if.sv | 32 +++
 rtl/fifo_umbrales.sv | 83 ++++++++
 tb/tb_fifo_umbrales.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_umbrales_if.sv
// Bus bundle for fifo_umbrales: write/read requests, thresholds and status.
// The producer/consumer side uses the master modport, the FIFO uses slave.
interface fifo_umbrales_if #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2
);
    logic                  push;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] umbral_alto;
    logic [ADDR_WIDTH-1:0] umbral_bajo;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  empty;
    logic                  full;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  error;
    logic [ADDR_WIDTH:0]   count;

    modport master (
        output push, data_in, pop, umbral_alto, umbral_bajo,
        input  data_out, valid_out, empty, full, almost_full, almost_empty,
               error, count
    );

    modport slave (
        input  push, data_in, pop, umbral_alto, umbral_bajo,
        output data_out, valid_out, empty, full, almost_full, almost_empty,
               error, count
    );
endinterface

// File: rtl/fifo_umbrales.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds and
// a sticky overflow/underflow error flag. Occupancy is kept in its own counter
// so full and empty are unambiguous even though the pointers wrap.
module fifo_umbrales #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    fifo_umbrales_if.slave    bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  error_q;

    logic pop_ok;
    logic push_ok;
    logic overflow;
    logic underflow;

    // Accept decisions; a push into a full FIFO is fine when a pop frees a slot.
    always_comb begin
        pop_ok    = bus.pop && (count_q != '0);
        push_ok   = bus.push && ((count_q < DEPTH_C) || pop_ok);
        overflow  = bus.push && (count_q == DEPTH_C) && !bus.pop;
        underflow = bus.pop && (count_q == '0);
    end

    // Storage array; contents are don't-care after reset so it has no reset.
    always_ff @(posedge clk) begin
        if (reset && push_ok) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // Pointers, occupancy, registered read data and the sticky error bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            valid_q <= pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                data_q <= mem[rd_ptr];
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - 1'b1;
            end
            if (overflow || underflow) begin
                error_q <= 1'b1;
            end
        end
    end

    // Status flags follow the registered count and the live threshold inputs.
    always_comb begin
        bus.count        = count_q;
        bus.data_out     = data_q;
        bus.valid_out    = valid_q;
        bus.error        = error_q;
        bus.empty        = (count_q == '0);
        bus.full         = (count_q == DEPTH_C);
        bus.almost_full  = (count_q >= (DEPTH_C - {1'b0, bus.umbral_alto}));
        bus.almost_empty = (count_q <= {1'b0, bus.umbral_bajo});
    end
endmodule

// File: tb/tb_fifo_umbrales.sv
// Scoreboarded bench for fifo_umbrales: directed scenarios plus random traffic,
// compared against a queue-based model of the FIFO behaviour.
module tb_fifo_umbrales;
    localparam int DW    = 6;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;

    fifo_umbrales_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fifo_umbrales #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks;
    int fails;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_q[$];
    bit            model_err;
    logic [DW-1:0] last_read;
    bit            mon_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Compare every status output against the model and the live thresholds.
    task automatic checkOutput();
        int n;
        int alto;
        int bajo;
        n    = model_q.size();
        alto = int'(bus.umbral_alto);
        bajo = int'(bus.umbral_bajo);
        cmp("count", 8'(bus.count), 8'(n));
        cmp("empty", 8'(bus.empty), 8'(n == 0));
        cmp("full", 8'(bus.full), 8'(n == DEPTH));
        cmp("almost_full", 8'(bus.almost_full), 8'(n >= DEPTH - alto));
        cmp("almost_empty", 8'(bus.almost_empty), 8'(n <= bajo));
        cmp("error", 8'(bus.error), 8'(model_err));
    endtask

    // One clock of traffic; the model decides acceptance from the FIFO rules.
    task automatic applyStimulus(input bit p, input bit r, input logic [DW-1:0] d);
        bit pop_ok;
        bit push_ok;
        bus.push    = p;
        bus.pop     = r;
        bus.data_in = d;
        pop_ok  = r && (model_q.size() > 0);
        push_ok = p && ((model_q.size() < DEPTH) || pop_ok);
        if (p && model_q.size() == DEPTH && !r) model_err = 1'b1;
        if (r && model_q.size() == 0) model_err = 1'b1;
        if (pop_ok) exp_q.push_back(model_q.pop_front());
        if (push_ok) model_q.push_back(d);
        @(posedge clk);
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        checkOutput();
    endtask

    // Reset cycle; push/pop may be active to show reset dominating them.
    task automatic doReset(input bit p, input bit r);
        reset    = 1'b0;
        bus.push = p;
        bus.pop  = r;
        bus.data_in = DW'($urandom);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        model_q.delete();
        exp_q.delete();
        model_err = 1'b0;
        last_read = '0;
        cmp("reset_valid", 8'(bus.valid_out), 8'd0);
        cmp("reset_data", 8'(bus.data_out), 8'd0);
        checkOutput();
    endtask

    // Monitor: every valid_out pulse consumes one expected word; otherwise
    // data_out must hold the last word read.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.valid_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    cmp("spurious_valid", 8'(bus.valid_out), 8'd0);
                end else begin
                    logic [DW-1:0] w;
                    w = exp_q.pop_front();
                    cmp("data_out", 8'(bus.data_out), 8'(w));
                    last_read = w;
                end
            end else begin
                cmp("valid_low", 8'(bus.valid_out), 8'd0);
                cmp("data_hold", 8'(bus.data_out), 8'(last_read));
            end
        end
    end

    initial begin
        logic [1:0] ae_table [4];
        checks = 0;
        fails  = 0;
        mon_en = 1'b0;
        model_err = 1'b0;
        last_read = '0;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        bus.data_in = '0;
        bus.umbral_alto = 2'd1;
        bus.umbral_bajo = 2'd1;
        reset = 1'b0;
        @(posedge clk);
        doReset(1'b0, 1'b0);
        mon_en = 1'b1;

        // Fill 1..4 with umbral_alto=1, then drain in order.
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 1'b0, DW'(i));
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, '0);
        applyStimulus(1'b0, 1'b0, '0);

        // Overflow: 0x3F dropped, original words still come out.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, DW'(8'h10 + i));
        applyStimulus(1'b1, 1'b0, 6'h3F);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, '0);

        // Underflow with simultaneous push of 0x15, then read it back.
        applyStimulus(1'b1, 1'b1, 6'h15);
        applyStimulus(1'b0, 1'b1, '0);
        applyStimulus(1'b0, 1'b0, '0);

        // Full FIFO with push+pop across the pointer wrap, no error.
        doReset(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, DW'(8'h20 + i));
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 6'h2A);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, '0);

        // Threshold sweep at count=2; flags must react without a clock edge.
        ae_table[0] = 2'd0; ae_table[1] = 2'd0; ae_table[2] = 2'd1; ae_table[3] = 2'd1;
        applyStimulus(1'b1, 1'b0, 6'h05);
        applyStimulus(1'b1, 1'b0, 6'h06);
        for (int b = 0; b < 4; b++) begin
            bus.umbral_bajo = AW'(b);
            #1;
            cmp("ae_sweep", 8'(bus.almost_empty), 8'(ae_table[b]));
            checkOutput();
        end
        bus.umbral_alto = 2'd0;
        #1;
        checkOutput();
        applyStimulus(1'b1, 1'b0, 6'h07);
        applyStimulus(1'b1, 1'b0, 6'h08);

        // Mid-stream reset with count=3 and error set.
        applyStimulus(1'b1, 1'b0, 6'h09);
        applyStimulus(1'b0, 1'b1, '0);
        applyStimulus(1'b0, 1'b0, '0);
        cmp("pre_reset_count", 8'(bus.count), 8'd3);
        cmp("pre_reset_error", 8'(bus.error), 8'd1);
        doReset(1'b1, 1'b1);

        // Random traffic with changing thresholds and rare resets.
        for (int i = 0; i < 400; i++) begin
            bus.umbral_alto = AW'($urandom_range(0, 3));
            bus.umbral_bajo = AW'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) begin
                applyStimulus(1'b0, 1'b0, '0);
                doReset(1'($urandom), 1'($urandom));
            end else begin
                applyStimulus(1'($urandom), 1'($urandom), DW'($urandom));
            end
        end

        // Every accepted pop must have produced its valid_out pulse.
        applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, '0);
        cmp("pending_reads", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
        $finish;
    end
endmodule
